// File: rtl/user_uart_pkg.sv
// Shared types and constants for the user-project UART transmitter.
//   uart_tx_state_t : transmit FSM states
//   UART_DATA_BITS  : data bits per frame (8N1)
//   UART_IDLE_LEVEL : line level while idle and during the stop bit
package user_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/user_uart_tx_fifo.sv
// Show-ahead synchronous byte FIFO for the UART transmitter.
//   wb_clk_i / wb_rst_i : clock, synchronous active-high reset
//   push / din          : write din when not full
//   pop  / dout         : dout is the head entry; pop discards it when not empty
//   full / empty        : occupancy flags
//   level               : current occupancy (0..FIFO_DEPTH)
module user_uart_tx_fifo
  import user_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          push,
  input  logic                          pop,
  input  logic [UART_DATA_BITS-1:0]     din,
  output logic [UART_DATA_BITS-1:0]     dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic                      do_push;
  logic                      do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/user_uart_tx.sv
// 8N1 UART transmitter with a small input FIFO.
//   wb_clk_i / wb_rst_i : clock, synchronous active-high reset
//   in_data / in_valid  : byte stream input, transfer when in_valid && in_ready
//   in_ready            : FIFO not full
//   tx                  : registered serial line, idle high
//   busy                : frame in progress or bytes queued
//   fifo_level          : FIFO occupancy
module user_uart_tx
  import user_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4167,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  uart_tx_state_t            state;
  logic [CW-1:0]             baud_cnt;
  logic [BW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      bit_last;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_dout;

  assign in_ready = !fifo_full;
  assign bit_last = (baud_cnt == CNT_LAST);
  // Pop from IDLE, or at the end of STOP so the next start bit follows with no gap.
  assign fifo_pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_last));
  assign busy     = (state != IDLE) || !fifo_empty;

  user_uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .push    (in_valid && in_ready),
    .pop     (fifo_pop),
    .din     (in_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= UART_IDLE_LEVEL;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx       <= UART_IDLE_LEVEL;
          if (fifo_pop) begin
            shift <= fifo_dout;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_last) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              tx    <= UART_IDLE_LEVEL;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_last) begin
            baud_cnt <= '0;
            if (fifo_pop) begin
              shift <= fifo_dout;
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= UART_IDLE_LEVEL;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_uart_tx.sv
// Directed self-checking bench for user_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_user_uart_tx;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  stream [6];

  user_uart_tx #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_level(fifo_level)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Checks the 40 samples of a frame starting at the current (start-bit) sample;
  // returns at the sample just after the frame's final edge.
  task automatic check_frame(input logic [7:0] b, input bit do_push, input logic [7:0] nb);
    logic       exp;
    logic [7:0] sh;
    int unsigned bi;
    for (int unsigned j = 0; j < 40; j++) begin
      bi = j / 4;
      if (bi == 0) exp = 1'b0;
      else if (bi == 9) exp = 1'b1;
      else begin
        sh  = b >> (bi - 1);
        exp = sh[0];
      end
      check($sformatf("frame_%02h_s%0d", b, j), 32'(tx), 32'(exp));
      if (j == 39) begin
        check("busy_last_stop", 32'(busy), 32'd1);
        if (do_push) begin
          in_data  = nb;
          in_valid = 1'b1;
        end
      end
      tick();
    end
    if (do_push) in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int unsigned t;
    t = 0;
    while (tx !== 1'b0 && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_one(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("push_level", 32'(fifo_level), 32'd1);
    check("tx_before_start", 32'(tx), 32'd1);
    tick();
    check_frame(b, 1'b0, 8'h00);
    check("busy_after_frame", 32'(busy), 32'd0);
  endtask

  task automatic run_stream(input int unsigned n, input bit change_data);
    fork
      begin
        for (int unsigned i = 0; i < n; i++) begin
          int unsigned waited;
          waited   = 0;
          in_data  = stream[i];
          in_valid = 1'b1;
          while (!in_ready && waited < 400) begin
            tick();
            waited++;
          end
          if (waited >= 400) check("accept_timeout", 32'd0, 32'd1);
          tick();
          if (i == 4) begin
            check("full_level", 32'(fifo_level), 32'd4);
            check("full_ready", 32'(in_ready), 32'd0);
          end
          if (i == 5) check("sixth_waited", 32'(waited > 0), 32'd1);
        end
        in_valid = 1'b0;
        if (change_data) begin
          in_data = 8'hEE;
          for (int unsigned k = 0; k < 30; k++) begin
            in_data = ~in_data;
            tick();
          end
        end
      end
      begin
        wait_start();
        for (int unsigned i = 0; i < n; i++) check_frame(stream[i], 1'b0, 8'h00);
      end
    join
    check("stream_busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned stray_low;

    // Reset state
    wb_rst_i = 1'b1;
    repeat (3) tick();
    wb_rst_i = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    tick();

    // Single bytes
    send_one(8'h55);
    send_one(8'hA3);

    // Six bytes, in_valid held high
    stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h03;
    stream[3] = 8'h04; stream[4] = 8'h05; stream[5] = 8'h06;
    run_stream(6, 1'b0);
    tick();

    // Reset mid-DATA of 0xFF with two bytes queued
    in_valid = 1'b1;
    in_data  = 8'hFF; tick();
    in_data  = 8'h11; tick();
    in_data  = 8'h22; tick();
    in_valid = 1'b0;
    check("queued_level", 32'(fifo_level), 32'd2);
    repeat (14) tick();
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    stray_low = 0;
    for (int unsigned k = 0; k < 60; k++) begin
      if (tx !== 1'b1) stray_low++;
      tick();
    end
    check("no_frames_after_rst", 32'(stray_low), 32'd0);
    send_one(8'h00);

    // Push landing on the last STOP cycle with the FIFO empty
    in_data  = 8'h81;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_frame(8'h81, 1'b1, 8'h7E);
    check("gap_tx_high", 32'(tx), 32'd1);
    check("gap_level", 32'(fifo_level), 32'd1);
    check("gap_busy", 32'(busy), 32'd1);
    tick();
    check_frame(8'h7E, 1'b0, 8'h00);
    check("gap_busy_end", 32'(busy), 32'd0);
    tick();

    // in_data toggled while full and in_valid low
    stream[0] = 8'h3C; stream[1] = 8'h5A; stream[2] = 8'h96;
    stream[3] = 8'hC3; stream[4] = 8'h0F;
    run_stream(5, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
